reg_dump_reader: RTL and testbench

Debug read-out engine for the simplified LC-3 8x16 register file. On a start pulse it walks R0..R7 through one register-file read port, one address per word, and streams each 16-bit value with its index over a valid/ready interface. The stream feeds the board's hex-display/UART debug path. It sits beside the datapath as a second reader of the register file and never writes to it.

---
 rtl/reg_dump_pkg.sv | 20 ++
 rtl/reg_dump_csum.sv | 30 +++
 rtl/reg_dump_reader.sv | 135 +++++++++++++
 tb/tb_reg_dump_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the LC-3 register-file dump reader.
// Holds the walker state encoding, the stream index width and the index
// tagged onto the optional checksum word.
package reg_dump_pkg;

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned RF_ADDR_W = 3;

  // Index carried by the trailing checksum word (one past R7).
  localparam logic [IDX_W-1:0] CSUM_IDX = 4'd8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/reg_dump_csum.sv
// Wrap-around accumulator for the dump checksum (carry out is dropped).
// Ports:
//   Clk    - system clock
//   Reset  - asynchronous active-low reset
//   clear  - synchronous clear to zero (has priority over add_en)
//   add_en - add din into the running sum this cycle
//   din    - word to accumulate
//   sum    - registered running sum, modulo 2^DATA_W
module reg_dump_csum #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: on a start pulse walks R0..R(NUM_REGS-1) of the
// register file through one read port and streams {index, value} words over
// a valid/ready interface. Never writes the register file.
// Optional feature: define REG_DUMP_CHECKSUM_EN to append a checksum word
// (index 8, modulo-2^DATA_W sum of the register words) after the last register.
// Ports:
//   Clk       - system clock
//   Reset     - asynchronous active-low reset
//   start     - one-cycle dump request, honoured only while idle
//   rd_addr   - register-file read select
//   rd_data   - combinational read data for rd_addr
//   out_data  - streamed word
//   out_idx   - register index of out_data (CSUM_IDX for the checksum)
//   out_valid - out_data/out_idx valid
//   out_ready - downstream accepts the word
//   busy      - dump in progress
//   done      - one-cycle pulse after the last word is accepted
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  output logic [RF_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic [DATA_W-1:0]    out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_sum;

  // Sum restarts every dump; each accepted register word is folded in.
  reg_dump_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (state == IDLE),
    .add_en ((state == SEND) && out_ready),
    .din    (out_data),
    .sum    (csum_sum)
  );
`endif

  // Walker FSM; rd_addr is kept one step ahead so it equals idx in READ.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= READ;
          end
        end

        READ: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              rd_addr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
              // Accumulator updates on this same edge, so fold R-last in here.
              out_data <= csum_sum + out_data;
              out_idx  <= CSUM_IDX;
              state    <= CSUM;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              idx       <= idx + 4'd1;
              rd_addr   <= RF_ADDR_W'(idx + 4'd1);
              state     <= READ;
            end
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
`endif

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader. The bench owns the 8x16 register
// file and predicts the stream from the register contents it sets up: the
// word list in index order, plus the wrapped sum when the checksum is built in.
module tb_reg_dump_reader;

  localparam int NREG = 8;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] rf [NREG];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign rd_data = rf[rd_addr];

  reg_dump_reader #(
    .DATA_W   (16),
    .NUM_REGS (NREG)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) rf[i] = 16'($urandom);
  endtask

  // One complete dump. Called at a negedge with the DUT idle.
  task automatic dump(input bit rnd, input int stall_word, input int stall_len,
                      input int poke_word, input int poke_reg, input logic [15:0] poke_val,
                      input int restart_n, input bit timed);
    logic [15:0] exp_d[$];
    logic [3:0]  exp_i[$];
    logic [15:0] sum;
    logic [15:0] pd;
    logic [3:0]  pi;
    int k, stall_cnt;
    bit got_done, pend, poked;

    sum = 16'h0;
    for (int i = 0; i < NREG; i++) begin
      logic [15:0] v;
      v = (poke_word >= 0 && i == poke_reg) ? poke_val : rf[i];
      exp_d.push_back(v);
      exp_i.push_back(4'(i));
      sum = sum + v;
    end
    if (CS == 1) begin
      exp_d.push_back(sum);
      exp_i.push_back(4'd8);
    end

    k = 0; stall_cnt = 0; got_done = 0; pend = 0; poked = 0;
    pd = '0; pi = '0;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge Clk);
    for (int n = 1; n <= 400 && !got_done; n++) begin
      if (n > 1) @(negedge Clk);
      start = (n == restart_n);
      chk("busy_during", busy, 1);
      if (done) begin
        got_done = 1;
        chk("done_words", k, exp_d.size());
        chk("done_valid", out_valid, 0);
        if (timed) chk("done_cycle", n, 2 * NREG + 1 + CS);
      end else if (!out_valid) begin
        if (pend) chk("valid_dropped", 0, 1);
        chk("rd_addr_read", rd_addr, k);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
      end else begin
        if (pend) begin
          chk("hold_data", out_data, pd);
          chk("hold_idx", out_idx, pi);
        end
        if (poke_word >= 0 && !poked && out_idx == 4'(poke_word)) begin
          rf[poke_reg] = poke_val;
          poked = 1;
        end
        if (stall_word >= 0 && out_idx == 4'(stall_word) && stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          if (k < exp_d.size()) begin
            chk("word_idx", out_idx, exp_i[k]);
            chk("word_data", out_data, exp_d[k]);
          end else begin
            chk("extra_word", 1, 0);
          end
          k++;
          pend = 0;
        end else begin
          pend = 1;
          pd = out_data;
          pi = out_idx;
        end
      end
    end
    start = 1'b0;
    if (!got_done) begin
      chk("dump_timeout", 0, 1);
    end else begin
      if (stall_len > 0) chk("stall_cycles", stall_cnt, stall_len);
      @(negedge Clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("valid_after_done", out_valid, 0);
      chk("rd_addr_idle", rd_addr, 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    Reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Reference preload, full-rate sink, cycle-exact timing.
    rf[0] = 16'h0001; rf[1] = 16'h0010; rf[2] = 16'h0100; rf[3] = 16'h1000;
    rf[4] = 16'h3000; rf[5] = 16'h5000; rf[6] = 16'h7000; rf[7] = 16'hFFFF;
    dump(0, -1, 0, -1, 0, 16'h0, -1, 1);

    // Sink stalls 5 cycles on R3.
    fill_random();
    dump(0, 3, 5, -1, 0, 16'h0, -1, 0);

    // start while busy (mid-dump, and in the done cycle) is ignored.
    fill_random();
    dump(0, -1, 0, -1, 0, 16'h0, 5, 1);
    fill_random();
    dump(0, -1, 0, -1, 0, 16'h0, 2 * NREG + 1 + CS, 1);

    // R5 rewritten while R2 is being handed over.
    fill_random();
    dump(0, -1, 0, 2, 5, 16'hBEEF, -1, 1);

    // Random back-pressure.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      dump(1, -1, 0, -1, 0, 16'h0, -1, 0);
    end

    // Reset while R4 is on the bus, then a clean restart from R0.
    fill_random();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      out_ready = (out_valid && out_idx == 4'd4) ? 1'b0 : 1'b1;
      if (out_valid && out_idx == 4'd4) seen = 1;
      else @(negedge Clk);
    end
    chk("reach_r4", seen, 1);
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    chk("mid_rst_done", done, 0);
    @(negedge Clk);
    Reset = 1'b1;
    out_ready = 1'b0;
    @(negedge Clk);
    chk("post_rst_idle", busy, 0);
    fill_random();
    dump(0, -1, 0, -1, 0, 16'h0, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
